// File: rtl/sig_scan_unit_pkg.sv
// Shared definitions for the signature-scan coprocessor: register map,
// CTRL/STATUS bit positions, FSM encoding and the CTRL command decoder.
package sig_scan_unit_pkg;

    localparam logic [4:0] SSU_CTRL   = 5'h00;
    localparam logic [4:0] SSU_SIG    = 5'h04;
    localparam logic [4:0] SSU_DATA   = 5'h08;
    localparam logic [4:0] SSU_STATUS = 5'h0C;
    localparam logic [4:0] SSU_MPOS   = 5'h10;
    localparam logic [4:0] SSU_BCNT   = 5'h14;

    localparam logic [31:0] SSU_WIN_BYTES = 32'h18;

    localparam int CTRL_START     = 0;
    localparam int CTRL_CLEAR     = 1;
    localparam int CTRL_SIG_CLEAR = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_MATCH   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_EMPTY   = 3;
    localparam int ST_SIG_LSB = 4;

    typedef enum logic [1:0] {
        SSU_IDLE    = 2'd0,
        SSU_SCAN    = 2'd1,
        SSU_MATCHED = 2'd2
    } ssu_state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_SIG_CLEAR,
        CMD_START
    } ctrl_cmd_e;

    // Only the highest-priority CTRL bit of a write takes effect.
    function automatic ctrl_cmd_e decode_ctrl(input logic [2:0] bits);
        ctrl_cmd_e cmd;
        cmd = CMD_NONE;
        if (bits[CTRL_CLEAR])          cmd = CMD_CLEAR;
        else if (bits[CTRL_SIG_CLEAR]) cmd = CMD_SIG_CLEAR;
        else if (bits[CTRL_START])     cmd = CMD_START;
        return cmd;
    endfunction

endpackage

// File: rtl/sig_scan_unit_word_fifo.sv
// Synchronous 32-bit word FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_cpu) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sig_scan_unit.sv
// Memory-mapped signature-scan coprocessor: buffers stored words, serialises
// them little-endian and reports the first sliding-window signature match.
module sig_scan_unit
    import sig_scan_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADRS  = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SIG_MAX    = 8
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [31:0] adrs,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    output logic [31:0] rd_data,
    output logic        irq
);
    localparam logic [3:0] SIG_MAX_L = 4'(SIG_MAX);

    logic [31:0] offset;
    logic [4:0]  reg_off;
    logic        in_win;
    logic        wr_sig, wr_data_sel;
    ctrl_cmd_e   cmd;

    ssu_state_e state_q, state_d;
    logic       busy;

    logic [31:0]              hold_q, hold_d;
    logic [2:0]               hold_cnt_q, hold_cnt_d;
    logic [SIG_MAX-1:0][7:0]  win_q, win_d, win_next;
    logic [SIG_MAX-1:0][7:0]  sig_q, sig_d;
    logic [3:0]               sig_len_q, sig_len_d;
    logic [31:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]              match_pos_q, match_pos_d;
    logic                     match_q, match_d;
    logic                     ovf_q, ovf_d;
    logic                     irq_q, irq_d;

    logic        consume, pop, sig_eq, match_hit;
    logic [32:0] cnt_plus1;
    logic        fifo_rst, fifo_full, fifo_empty;
    logic [31:0] fifo_dout;
    logic [31:0] status;

    assign offset      = adrs - BASE_ADRS;
    assign in_win      = (offset < SSU_WIN_BYTES);
    assign reg_off     = {offset[4:2], 2'b00};
    assign cmd         = (wr_en && in_win && reg_off == SSU_CTRL) ? decode_ctrl(wr_data[2:0]) : CMD_NONE;
    assign wr_sig      = wr_en && in_win && (reg_off == SSU_SIG);
    assign wr_data_sel = wr_en && in_win && (reg_off == SSU_DATA);
    assign fifo_rst    = reset || (cmd == CMD_CLEAR);

    word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_cpu (clk_cpu),
        .reset   (fifo_rst),
        .push    (wr_data_sel),
        .pop     (pop),
        .din     (wr_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_cpu) begin
        if (reset) state_q <= SSU_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd == CMD_CLEAR) begin
            state_d = SSU_IDLE;
        end else begin
            case (state_q)
                SSU_IDLE:    if (cmd == CMD_START) state_d = SSU_SCAN;
                SSU_SCAN:    if (match_hit)        state_d = SSU_MATCHED;
                SSU_MATCHED: state_d = SSU_MATCHED;
                default:     state_d = SSU_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == SSU_SCAN);
    end

    // The next pop overlaps the last byte of the held word to keep 1 byte/cycle.
    assign consume   = busy && (hold_cnt_q != 3'd0);
    assign pop       = busy && !fifo_empty && (hold_cnt_q <= 3'd1);
    assign cnt_plus1 = {1'b0, byte_cnt_q} + 33'd1;

    // The signature is held newest-first so index k lines up with window index k.
    always_comb begin
        win_next    = win_q;
        win_next[0] = hold_q[7:0];
        for (int k = 1; k < SIG_MAX; k++) win_next[k] = win_q[k-1];
        sig_eq = 1'b1;
        for (int k = 0; k < SIG_MAX; k++) begin
            if ((k < int'(sig_len_q)) && (win_next[k] != sig_q[k])) sig_eq = 1'b0;
        end
        match_hit = consume && (sig_len_q != 4'd0) && (cnt_plus1 >= {29'd0, sig_len_q}) && sig_eq;
    end

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        win_d       = win_q;
        sig_d       = sig_q;
        sig_len_d   = sig_len_q;
        byte_cnt_d  = byte_cnt_q;
        match_pos_d = match_pos_q;
        match_d     = match_q;
        ovf_d       = ovf_q;
        if (cmd == CMD_CLEAR) begin
            hold_d      = '0;
            hold_cnt_d  = '0;
            win_d       = '0;
            byte_cnt_d  = '0;
            match_pos_d = '0;
            match_d     = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (cmd == CMD_SIG_CLEAR) sig_len_d = '0;
            if (wr_sig && (sig_len_q < SIG_MAX_L)) begin
                sig_d[0] = wr_data[7:0];
                for (int k = 1; k < SIG_MAX; k++) sig_d[k] = sig_q[k-1];
                sig_len_d = sig_len_q + 4'd1;
            end
            if (wr_data_sel && fifo_full && !pop) ovf_d = 1'b1;
            if (pop) begin
                hold_d     = fifo_dout;
                hold_cnt_d = 3'd4;
            end else if (consume) begin
                hold_d     = {8'h00, hold_q[31:8]};
                hold_cnt_d = hold_cnt_q - 3'd1;
            end
            if (consume) begin
                win_d = win_next;
                if (byte_cnt_q != 32'hFFFF_FFFF) byte_cnt_d = byte_cnt_q + 32'd1;
            end
            if (match_hit) begin
                match_d     = 1'b1;
                match_pos_d = byte_cnt_q;
            end
        end
        irq_d = (state_d == SSU_MATCHED);
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            win_q       <= '0;
            sig_q       <= '0;
            sig_len_q   <= '0;
            byte_cnt_q  <= '0;
            match_pos_q <= '0;
            match_q     <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            win_q       <= win_d;
            sig_q       <= sig_d;
            sig_len_q   <= sig_len_d;
            byte_cnt_q  <= byte_cnt_d;
            match_pos_q <= match_pos_d;
            match_q     <= match_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        status                      = '0;
        status[ST_BUSY]             = busy;
        status[ST_MATCH]            = match_q;
        status[ST_OVF]              = ovf_q;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_SIG_LSB +: 4]     = sig_len_q;
        rd_data = '0;
        if (in_win) begin
            case (reg_off)
                SSU_STATUS: rd_data = status;
                SSU_MPOS:   rd_data = match_pos_q;
                SSU_BCNT:   rd_data = byte_cnt_q;
                default:    rd_data = '0;
            endcase
        end
    end

endmodule
